mips_multicycle_controller: RTL



---
 rtl/mips_multicycle_controller_pkg.sv | 50 +++++
 rtl/mips_multicycle_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller_pkg.sv
// Shared MIPS encodings: opcodes, ALU-decoder op codes, controller states and mux selects.
// The ERR state exists only when MIPS_CTRL_ERR_TRAP_EN is defined.
package mips_multicycle_controller_pkg;

  typedef enum logic [5:0] {
    R_Type_Opc = 6'b000000,
    J_Opc      = 6'b000010,
    BEQ_Opc    = 6'b000100,
    ADDI_Opc   = 6'b001000,
    LW_Opc     = 6'b100011,
    SW_Opc     = 6'b101011
  } opcode_t;

  typedef enum logic [1:0] {
    ADD_Op    = 2'b00,
    SUB_Op    = 2'b01,
    R_Type_Op = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    RST_IDLE,
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    R_EXEC,
    R_WB,
    ADDI_EXEC,
    ADDI_WB,
    BRANCH,
`ifdef MIPS_CTRL_ERR_TRAP_EN
    JUMP,
    ERR
`else
    JUMP
`endif
  } ctrl_state_t;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SL2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main control FSM (Moore; mem_ready qualifies ir_write/pc_write in FETCH).
// Define MIPS_CTRL_ERR_TRAP_EN to trap illegal opcodes in a sticky ERR state.
module mips_multicycle_controller
  import mips_multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  opcode_t    opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output alu_op_t    alu_op,
  output logic       err
);

  ctrl_state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_src        = PC_SRC_ALU;
    alu_op        = ADD_Op;
    err           = 1'b0;

    case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        // Qualifying with mem_ready gives exactly one PC increment however long the fetch waits.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = SRC_B_IMM_SL2;
        case (opcode)
          LW_Opc, SW_Opc: state_d = MEM_ADR;
          R_Type_Opc:     state_d = R_EXEC;
          ADDI_Opc:       state_d = ADDI_EXEC;
          BEQ_Opc:        state_d = BRANCH;
          J_Opc:          state_d = JUMP;
`ifdef MIPS_CTRL_ERR_TRAP_EN
          default:        state_d = ERR;
`else
          default:        state_d = FETCH;
`endif
        endcase
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == SW_Opc) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = R_Type_Op;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = SUB_Op;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        state_d  = FETCH;
      end
`ifdef MIPS_CTRL_ERR_TRAP_EN
      ERR: err = 1'b1;
`endif
      default: state_d = RST_IDLE;
    endcase
  end

endmodule
